// File: rtl/tdm_pkg.sv
// tdm_pkg: shared types and constants for the 4:1 TDM mux/demux pair
package tdm_pkg;
    typedef enum logic {HUNT, RUN} state_t;
    localparam int NUM_SLOTS = 4;
    localparam int SLOT_W    = 2;
endpackage

// File: rtl/tdm_slot_ctr.sv
// tdm_slot_ctr: 2-bit wrapping slot counter with clear, load-to-1 and enable
module tdm_slot_ctr
    import tdm_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_en,
    input  logic              i_load,
    input  logic              i_clr,
    output logic [SLOT_W-1:0] o_cnt
);
    logic [SLOT_W-1:0] r_cnt;

    // clear wins over load, load wins over increment
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_cnt <= '0;
        else if (i_clr)
            r_cnt <= '0;
        else if (i_load)
            r_cnt <= SLOT_W'(1);
        else if (i_en)
            r_cnt <= r_cnt + SLOT_W'(1);
    end

    assign o_cnt = r_cnt;
endmodule

// File: rtl/tdm_demux_4x1.sv
// tdm_demux_4x1: frame-aligned 1:4 TDM demultiplexer with lock tracking and error pulses
module tdm_demux_4x1
    import tdm_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int STRICT = 1,
    parameter int CNT_W  = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    input  logic             frame_sync,
    output logic [WIDTH-1:0] d0,
    output logic [WIDTH-1:0] d1,
    output logic [WIDTH-1:0] d2,
    output logic [WIDTH-1:0] d3,
    output logic             frame_valid,
    output logic             locked,
    output logic             sync_err,
    output logic [CNT_W-1:0] frame_cnt
);
    state_t            r_state;
    logic [WIDTH-1:0]  r_slot [NUM_SLOTS-1];
    logic [WIDTH-1:0]  r_d [NUM_SLOTS];
    logic              r_fv;
    logic              r_err;
    logic [CNT_W-1:0]  r_fcnt;
    logic [SLOT_W-1:0] w_cnt;
    logic              w_run;
    logic              w_hunt_hit;
    logic              w_early;
    logic              w_miss;
    logic              w_take;
    logic              w_done;
    logic              w_load;

    // marker while mid-frame restarts at slot 0; a missing marker only matters in strict mode
    always_comb begin
        w_run      = din_valid && (r_state == RUN);
        w_hunt_hit = din_valid && (r_state == HUNT) && frame_sync;
        w_early    = w_run && frame_sync && (w_cnt != '0);
        w_miss     = w_run && !frame_sync && (w_cnt == '0) && (STRICT != 0);
        w_take     = w_run && !w_early && !w_miss;
        w_done     = w_take && (w_cnt == SLOT_W'(NUM_SLOTS - 1));
        w_load     = w_hunt_hit || w_early;
    end

    tdm_slot_ctr u_ctr (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_en   (w_take),
        .i_load (w_load),
        .i_clr  (w_miss),
        .o_cnt  (w_cnt)
    );

    // FSM, slot capture and output registers; the slot-3 word bypasses straight into d3
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= HUNT;
            for (int i = 0; i < NUM_SLOTS - 1; i++) r_slot[i] <= '0;
            for (int i = 0; i < NUM_SLOTS; i++) r_d[i] <= '0;
            r_fv    <= 1'b0;
            r_err   <= 1'b0;
            r_fcnt  <= '0;
        end else begin
            r_fv  <= w_done;
            r_err <= w_early || w_miss;
            if (w_load)
                r_slot[0] <= din;
            else if (w_take && !w_done)
                r_slot[w_cnt] <= din;
            if (w_done) begin
                for (int i = 0; i < NUM_SLOTS - 1; i++) r_d[i] <= r_slot[i];
                r_d[NUM_SLOTS-1] <= din;
                r_fcnt <= r_fcnt + CNT_W'(1);
            end
            if (w_hunt_hit)
                r_state <= RUN;
            else if (w_miss)
                r_state <= HUNT;
        end
    end

    assign d0          = r_d[0];
    assign d1          = r_d[1];
    assign d2          = r_d[2];
    assign d3          = r_d[3];
    assign frame_valid = r_fv;
    assign sync_err    = r_err;
    assign locked      = (r_state == RUN);
    assign frame_cnt   = r_fcnt;
endmodule

// File: tb/tb_tdm_demux_4x1.sv
// tb_tdm_demux_4x1: scoreboard bench driving a strict/2-bit-counter and a flywheel/8-bit-counter demux in parallel
module tb_tdm_demux_4x1;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] din = '0;
    logic       din_valid = 1'b0;
    logic       frame_sync = 1'b0;

    logic [7:0] s_d [4];
    logic [7:0] f_d [4];
    logic       s_fv, s_lk, s_err, f_fv, f_lk, f_err;
    logic [1:0] s_cnt;
    logic [7:0] f_cnt;

    int npass = 0;
    int ntot  = 0;
    int nerr_s = 0;
    int nerr_f = 0;
    int ns = 0;
    int nf = 0;
    logic [39:0] q_s [$];
    logic [39:0] q_f [$];

    always #5 clk = ~clk;

    tdm_demux_4x1 #(.WIDTH(8), .STRICT(1), .CNT_W(2)) u_s (
        .clk(clk), .rst_n(rst_n), .din(din), .din_valid(din_valid), .frame_sync(frame_sync),
        .d0(s_d[0]), .d1(s_d[1]), .d2(s_d[2]), .d3(s_d[3]),
        .frame_valid(s_fv), .locked(s_lk), .sync_err(s_err), .frame_cnt(s_cnt)
    );

    tdm_demux_4x1 #(.WIDTH(8), .STRICT(0), .CNT_W(8)) u_f (
        .clk(clk), .rst_n(rst_n), .din(din), .din_valid(din_valid), .frame_sync(frame_sync),
        .d0(f_d[0]), .d1(f_d[1]), .d2(f_d[2]), .d3(f_d[3]),
        .frame_valid(f_fv), .locked(f_lk), .sync_err(f_err), .frame_cnt(f_cnt)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        ntot++;
        if (got === exp) npass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic word(input logic [7:0] d, input logic s);
        din = d;
        frame_sync = s;
        din_valid = 1'b1;
        @(posedge clk);
        #1;
        din_valid = 1'b0;
        frame_sync = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic expect_frame(input logic [7:0] a, b, c, d, input bit to_s, input bit to_f);
        if (to_s) begin
            ns++;
            q_s.push_back({a, b, c, d, 8'(ns % 4)});
        end
        if (to_f) begin
            nf++;
            q_f.push_back({a, b, c, d, 8'(nf % 256)});
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_s"}, {s_d[0], s_d[1], s_d[2], s_d[3], s_fv, s_lk, s_err, s_cnt}, '0);
        chk({tag, "_f"}, {f_d[0], f_d[1], f_d[2], f_d[3], f_fv, f_lk, f_err, f_cnt}, '0);
    endtask

    // scoreboard pop on each strobe, plus error-pulse bookkeeping
    always @(negedge clk) begin
        if (rst_n) begin
            if (s_fv && s_err) chk("s_fv_err_excl", 1, 0);
            if (f_fv && f_err) chk("f_fv_err_excl", 1, 0);
            if (s_err) nerr_s++;
            if (f_err) nerr_f++;
            if (s_fv) begin
                if (q_s.size() == 0) chk("s_unexpected_frame", 1, 0);
                else chk("s_frame", {s_d[0], s_d[1], s_d[2], s_d[3], 6'b0, s_cnt}, q_s.pop_front());
            end
            if (f_fv) begin
                if (q_f.size() == 0) chk("f_unexpected_frame", 1, 0);
                else chk("f_frame", {f_d[0], f_d[1], f_d[2], f_d[3], f_cnt}, q_f.pop_front());
            end
        end
    end

    initial begin
        #12;
        chk_zero("rst_hold");
        @(negedge clk);
        rst_n = 1'b1;
        idle(2);
        chk_zero("rst_rel");

        // clean frame; also garbage before the marker is ignored
        word(8'h99, 1'b0);
        chk("s_hunt_lock", s_lk, 0);
        expect_frame(8'hA1, 8'hB2, 8'hC3, 8'hD4, 1, 1);
        word(8'hA1, 1'b1);
        chk("s_lock_rise", s_lk, 1);
        word(8'hB2, 1'b0);
        word(8'hC3, 1'b0);
        word(8'hD4, 1'b0);
        chk("s_fv_lat", s_fv, 1);
        chk("f_fv_lat", f_fv, 1);
        idle(1);
        chk("s_fv_pulse", s_fv, 0);
        chk("s_hold_d0", s_d[0], 8'hA1);

        // gaps between B2 and C3
        expect_frame(8'hA1, 8'hB2, 8'hC3, 8'hD4, 1, 1);
        word(8'hA1, 1'b1);
        word(8'hB2, 1'b0);
        idle(3);
        chk("gap_no_fv", s_fv, 0);
        word(8'hC3, 1'b0);
        chk("gap_no_fv2", s_fv, 0);
        word(8'hD4, 1'b0);
        chk("gap_fv", s_fv, 1);
        idle(1);
        chk("gap_errs", nerr_s + nerr_f, 0);

        // early marker drops the 11/22 fragment
        word(8'h11, 1'b1);
        word(8'h22, 1'b0);
        expect_frame(8'h33, 8'h44, 8'h55, 8'h66, 1, 1);
        word(8'h33, 1'b1);
        chk("early_err_s", s_err, 1);
        chk("early_err_f", f_err, 1);
        word(8'h44, 1'b0);
        chk("early_err_pulse", s_err, 0);
        word(8'h55, 1'b0);
        word(8'h66, 1'b0);
        idle(1);

        // missing marker on the second of two back-to-back frames
        expect_frame(8'h01, 8'h02, 8'h03, 8'h04, 1, 1);
        word(8'h01, 1'b1);
        word(8'h02, 1'b0);
        word(8'h03, 1'b0);
        word(8'h04, 1'b0);
        expect_frame(8'h05, 8'h06, 8'h07, 8'h08, 0, 1);
        word(8'h05, 1'b0);
        chk("miss_err_s", s_err, 1);
        chk("miss_err_f", f_err, 0);
        chk("miss_unlock_s", s_lk, 0);
        word(8'h06, 1'b0);
        word(8'h07, 1'b0);
        word(8'h08, 1'b0);
        chk("miss_no_fv_s", s_fv, 0);
        chk("miss_fv_f", f_fv, 1);
        chk("miss_lock_f", f_lk, 1);
        expect_frame(8'h09, 8'h0A, 8'h0B, 8'h0C, 1, 1);
        word(8'h09, 1'b1);
        chk("relock_s", s_lk, 1);
        word(8'h0A, 1'b0);
        word(8'h0B, 1'b0);
        word(8'h0C, 1'b0);
        idle(1);
        chk("wrap_cnt_s", s_cnt, 2'd1);
        chk("cnt_f", f_cnt, 8'd6);

        // asynchronous reset mid-frame
        word(8'hE1, 1'b1);
        word(8'hE2, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        chk_zero("mid_rst");
        chk("q_empty_pre_rst", q_s.size() + q_f.size(), 0);
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        ns = 0;
        nf = 0;
        idle(1);
        word(8'h77, 1'b0);
        word(8'h88, 1'b0);
        chk("post_rst_hunt", s_lk | f_lk, 0);
        expect_frame(8'hF1, 8'hF2, 8'hF3, 8'hF4, 1, 1);
        word(8'hF1, 1'b1);
        word(8'hF2, 1'b0);
        word(8'hF3, 1'b0);
        word(8'hF4, 1'b0);
        idle(3);

        chk("q_s_drained", q_s.size(), 0);
        chk("q_f_drained", q_f.size(), 0);
        chk("nerr_s", nerr_s, 2);
        chk("nerr_f", nerr_f, 1);
        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end
endmodule
